// File: rtl/bin_sched.sv
// bin_sched: walks the bins of a partitioned CNF in order, sequencing
// load, core solve, store-back and cross-bin backtrack for each bin, and
// reports the global SAT/UNSAT verdict. Sole master of the core start/done
// handshake. All outputs are registered.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start_i; verdict outputs hold last result
// LOAD      | loading cur_bin_o, waiting for done_load_i
// CORE      | core solving cur_bin_o, waiting for done_core_i
// STORE     | writing back cur_bin_o, then choosing next bin / verdict
// BKT       | cross-bin backtrack to bkt_bin_o, waiting for done_bkt_i
// FIN_SAT   | one cycle: publish SAT and pulse done_o
// FIN_UNSAT | one cycle: publish UNSAT and pulse done_o
module bin_sched #(
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_CNT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [WIDTH_BIN_ID-1:0] num_bins_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    sat_o,
    output logic                    unsat_o,
    output logic                    err_o,
    output logic [WIDTH_BIN_ID-1:0] cur_bin_o,
    output logic                    start_load_o,
    input  logic                    done_load_i,
    output logic                    start_core_o,
    input  logic                    done_core_i,
    input  logic                    sat_i,
    input  logic                    unsat_i,
    input  logic [WIDTH_BIN_ID-1:0] bkt_bin_i,
    input  logic                    root_conflict_i,
    output logic                    start_store_o,
    input  logic                    done_store_i,
    output logic                    start_bkt_o,
    output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
    input  logic                    done_bkt_i,
    output logic [WIDTH_CNT-1:0]    load_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CORE, S_STORE, S_BKT, S_FIN_SAT, S_FIN_UNSAT
    } state_t;

    state_t                  state, state_nxt;
    logic [WIDTH_BIN_ID-1:0] num_bins_r;
    logic                    res_sat;
    logic                    res_root;
    logic                    core_sat;
    logic                    core_bad;
    logic                    last_bin;
    logic                    bkt_illegal;

    // Core answer is only trustworthy when exactly one of sat_i/unsat_i is set.
    assign core_sat    = sat_i & ~unsat_i;
    assign core_bad    = ~(sat_i ^ unsat_i);
    // num_bins_r is at least 1 whenever STORE is reached, so this never wraps.
    assign last_bin    = (cur_bin_o == num_bins_r - WIDTH_BIN_ID'(1));
    assign bkt_illegal = (bkt_bin_o >= cur_bin_o);

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = (num_bins_i == '0) ? S_FIN_SAT : S_LOAD;
            S_LOAD:  if (done_load_i) state_nxt = S_CORE;
            S_CORE:  if (done_core_i) state_nxt = S_STORE;
            S_STORE: begin
                if (done_store_i) begin
                    if (res_sat)                        state_nxt = last_bin ? S_FIN_SAT : S_LOAD;
                    else if (res_root || bkt_illegal)   state_nxt = S_FIN_UNSAT;
                    else                                state_nxt = S_BKT;
                end
            end
            S_BKT:       if (done_bkt_i) state_nxt = S_LOAD;
            S_FIN_SAT:   state_nxt = S_IDLE;
            S_FIN_UNSAT: state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Registered outputs, request strobes on state entry, and bin/result bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            sat_o         <= 1'b0;
            unsat_o       <= 1'b0;
            err_o         <= 1'b0;
            cur_bin_o     <= '0;
            bkt_bin_o     <= '0;
            load_cnt_o    <= '0;
            start_load_o  <= 1'b0;
            start_core_o  <= 1'b0;
            start_store_o <= 1'b0;
            start_bkt_o   <= 1'b0;
            num_bins_r    <= '0;
            res_sat       <= 1'b0;
            res_root      <= 1'b0;
        end else begin
            busy_o        <= (state_nxt != S_IDLE);
            done_o        <= (state == S_FIN_SAT) || (state == S_FIN_UNSAT);
            start_load_o  <= (state_nxt == S_LOAD)  && (state != S_LOAD);
            start_core_o  <= (state_nxt == S_CORE)  && (state != S_CORE);
            start_store_o <= (state_nxt == S_STORE) && (state != S_STORE);
            start_bkt_o   <= (state_nxt == S_BKT)   && (state != S_BKT);
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        sat_o      <= 1'b0;
                        unsat_o    <= 1'b0;
                        err_o      <= 1'b0;
                        load_cnt_o <= '0;
                        cur_bin_o  <= '0;
                        num_bins_r <= num_bins_i;
                    end
                end
                S_LOAD: begin
                    if (done_load_i && (load_cnt_o != '1))
                        load_cnt_o <= load_cnt_o + WIDTH_CNT'(1);
                end
                S_CORE: begin
                    if (done_core_i) begin
                        bkt_bin_o <= bkt_bin_i;
                        res_sat   <= core_sat;
                        // An inconsistent answer is treated as a root-level conflict.
                        res_root  <= core_bad | root_conflict_i;
                        if (core_bad) err_o <= 1'b1;
                    end
                end
                S_STORE: begin
                    if (done_store_i) begin
                        if (res_sat && !last_bin)
                            cur_bin_o <= cur_bin_o + WIDTH_BIN_ID'(1);
                        else if (!res_sat && !res_root && bkt_illegal)
                            err_o <= 1'b1;
                    end
                end
                S_BKT: begin
                    if (done_bkt_i) cur_bin_o <= bkt_bin_o;
                end
                S_FIN_SAT: begin
                    sat_o   <= 1'b1;
                    unsat_o <= 1'b0;
                end
                S_FIN_UNSAT: begin
                    unsat_o <= 1'b1;
                    sat_o   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_sched.sv
// tb_bin_sched: directed scenarios against an event-level model of the
// bin walk. The model turns the per-core-call answer table into the ordered
// list of strobes (load/core/store/bkt requests and done) the scheduler must
// produce, each with the cur_bin/load_cnt/bkt_bin/verdict visible at that strobe.
module tb_bin_sched;

    localparam int WB   = 10;
    localparam int WC   = 4;
    localparam int MAXC = 15;

    localparam int EV_LOAD  = 1;
    localparam int EV_CORE  = 2;
    localparam int EV_STORE = 3;
    localparam int EV_BKT   = 4;
    localparam int EV_DONE  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [WB-1:0] num_bins_i;
    logic          busy_o, done_o, sat_o, unsat_o, err_o;
    logic [WB-1:0] cur_bin_o;
    logic          start_load_o, done_load_i;
    logic          start_core_o, done_core_i;
    logic          sat_i, unsat_i, root_conflict_i;
    logic [WB-1:0] bkt_bin_i;
    logic          start_store_o, done_store_i;
    logic          start_bkt_o, done_bkt_i;
    logic [WB-1:0] bkt_bin_o;
    logic [WC-1:0] load_cnt_o;

    always #5 clk = ~clk;

    bin_sched #(.WIDTH_BIN_ID(WB), .WIDTH_CNT(WC)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .num_bins_i(num_bins_i),
        .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o), .err_o(err_o),
        .cur_bin_o(cur_bin_o),
        .start_load_o(start_load_o), .done_load_i(done_load_i),
        .start_core_o(start_core_o), .done_core_i(done_core_i),
        .sat_i(sat_i), .unsat_i(unsat_i), .bkt_bin_i(bkt_bin_i), .root_conflict_i(root_conflict_i),
        .start_store_o(start_store_o), .done_store_i(done_store_i),
        .start_bkt_o(start_bkt_o), .bkt_bin_o(bkt_bin_o), .done_bkt_i(done_bkt_i),
        .load_cnt_o(load_cnt_o)
    );

    typedef struct {
        int kind;
        int cur;
        int cnt;
        int bkt;
        bit sat;
        bit unsat;
        bit err;
    } ev_t;

    ev_t exp_q[512];
    int  wr = 0;
    int  sync_pos = 0;
    int  run_id = 0;

    bit  t_sat[64], t_unsat[64], t_root[64];
    int  t_bkt[64];
    int  lat_load, lat_core, lat_store, lat_bkt;
    bit  inj_load;

    int  n_cmp = 0, n_bad = 0;
    int  b_ld, b_co, b_st, b_bk;

    task automatic push(input int kind, input int cur, input int cnt, input int bkt,
                        input bit s, input bit u, input bit e);
        if (wr < 512) begin
            exp_q[wr] = '{kind, cur, cnt, bkt, s, u, e};
            wr++;
        end
    endtask

    // Model: walk bins using the answer table, emitting the expected strobes.
    task automatic build(input int nb);
        int cur, cnt, k, bkt;
        bit err, s, u, rt;
        cur = 0; cnt = 0; k = 0; err = 0;
        if (nb == 0) begin
            push(EV_DONE, 0, 0, 0, 1, 0, 0);
            return;
        end
        for (int step = 0; step < 64; step++) begin
            push(EV_LOAD, cur, cnt, 0, 0, 0, 0);
            if (cnt < MAXC) cnt++;
            push(EV_CORE, cur, cnt, 0, 0, 0, 0);
            s = t_sat[k]; u = t_unsat[k]; rt = t_root[k]; bkt = t_bkt[k];
            k++;
            if (s == u) begin
                err = 1; s = 0; rt = 1;
            end
            push(EV_STORE, cur, cnt, bkt, 0, 0, 0);
            if (s) begin
                if (cur == nb - 1) begin
                    push(EV_DONE, cur, cnt, 0, 1, 0, err);
                    return;
                end
                cur++;
            end else if (rt) begin
                push(EV_DONE, cur, cnt, 0, 0, 1, err);
                return;
            end else if (bkt >= cur) begin
                push(EV_DONE, cur, cnt, 0, 0, 1, 1);
                return;
            end else begin
                push(EV_BKT, cur, cnt, bkt, 0, 0, 0);
                cur = bkt;
            end
        end
    endtask

    task automatic set_all_sat();
        for (int i = 0; i < 64; i++) begin
            t_sat[i] = 1; t_unsat[i] = 0; t_root[i] = 0; t_bkt[i] = 0;
        end
    endtask

    // Responders: each unit answers its request after a programmable latency.
    int p_ld = -1, p_co = -1, p_st = -1, p_bk = -1, k_core = 0, run_seen = 0;
    bit inj_pend = 0;
    always begin
        @(posedge clk); #1;
        done_load_i = 0; done_core_i = 0; done_store_i = 0; done_bkt_i = 0;
        sat_i = 0; unsat_i = 0; root_conflict_i = 0; bkt_bin_i = '0;
        if (run_seen != run_id) begin
            run_seen = run_id;
            k_core = 0;
        end
        if (!rst) begin
            p_ld = -1; p_co = -1; p_st = -1; p_bk = -1; inj_pend = 0;
        end else begin
            if (inj_pend) begin
                done_load_i = 1;
                inj_pend = 0;
            end
            if (start_load_o)  p_ld = lat_load;
            if (start_core_o) begin
                p_co = lat_core;
                inj_pend = inj_load;
            end
            if (start_store_o) p_st = lat_store;
            if (start_bkt_o)   p_bk = lat_bkt;
            if (p_ld == 0) begin done_load_i = 1; p_ld = -1; end
            else if (p_ld > 0) p_ld--;
            if (p_co == 0) begin
                done_core_i = 1;
                sat_i = t_sat[k_core]; unsat_i = t_unsat[k_core];
                root_conflict_i = t_root[k_core]; bkt_bin_i = WB'(t_bkt[k_core]);
                if (k_core < 63) k_core++;
                p_co = -1;
            end else if (p_co > 0) p_co--;
            if (p_st == 0) begin done_store_i = 1; p_st = -1; end
            else if (p_st > 0) p_st--;
            if (p_bk == 0) begin done_bkt_i = 1; p_bk = -1; end
            else if (p_bk > 0) p_bk--;
        end
    end

    // Compare process: every strobe must match the next expected model event.
    int  rd = 0, c_cmp = 0, c_bad = 0;
    int  n_ld = 0, n_co = 0, n_st = 0, n_bk = 0;
    int  nhi, kind;
    ev_t e;
    bit  ok;
    always @(negedge clk) begin
        if (rd < sync_pos) rd = sync_pos;
        if (start_load_o)  n_ld++;
        if (start_core_o)  n_co++;
        if (start_store_o) n_st++;
        if (start_bkt_o)   n_bk++;
        nhi = int'(start_load_o) + int'(start_core_o) + int'(start_store_o) + int'(start_bkt_o) + int'(done_o);
        if (nhi > 1) begin
            c_cmp++; c_bad++;
            $display("FAIL strobe_overlap: %0d strobes high together, required at most 1", nhi);
        end else if (nhi == 1) begin
            kind = start_load_o ? EV_LOAD : start_core_o ? EV_CORE : start_store_o ? EV_STORE :
                   start_bkt_o ? EV_BKT : EV_DONE;
            c_cmp++;
            if (rd >= wr) begin
                c_bad++;
                $display("FAIL unexpected_strobe: got kind=%0d cur=%0d, required no strobe", kind, cur_bin_o);
            end else begin
                e = exp_q[rd];
                rd++;
                ok = (kind == e.kind) && (int'(cur_bin_o) == e.cur) && (int'(load_cnt_o) == e.cnt);
                if (e.kind == EV_STORE || e.kind == EV_BKT) ok = ok && (int'(bkt_bin_o) == e.bkt);
                if (e.kind == EV_DONE)
                    ok = ok && (sat_o == e.sat) && (unsat_o == e.unsat) && (err_o == e.err) && !busy_o;
                if (!ok) begin
                    c_bad++;
                    $display("FAIL event_%0d: got kind=%0d cur=%0d cnt=%0d bkt=%0d sat=%0b unsat=%0b err=%0b busy=%0b, required kind=%0d cur=%0d cnt=%0d bkt=%0d sat=%0b unsat=%0b err=%0b",
                             rd - 1, kind, cur_bin_o, load_cnt_o, bkt_bin_o, sat_o, unsat_o, err_o, busy_o,
                             e.kind, e.cur, e.cnt, e.bkt, e.sat, e.unsat, e.err);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic snap();
        b_ld = n_ld; b_co = n_co; b_st = n_st; b_bk = n_bk;
    endtask

    function automatic int any_out();
        return int'(|{busy_o, done_o, sat_o, unsat_o, err_o, cur_bin_o, start_load_o, start_core_o,
                      start_store_o, start_bkt_o, bkt_bin_o, load_cnt_o});
    endfunction

    // One solve: build expectations, start, wait (bounded) for done_o.
    task automatic run(input string nm, input int nb, input bit inj_st, input int exp_ev, output int cyc);
        sync_pos = wr;
        run_id++;
        build(nb);
        if (exp_ev >= 0) chk({nm, "_model_events"}, wr - sync_pos, exp_ev);
        snap();
        @(negedge clk);
        num_bins_i = WB'(nb);
        start_i = 1;
        @(negedge clk);
        start_i = 0;
        cyc = 1;
        chk({nm, "_busy_after_start"}, int'(busy_o), 1);
        while (!done_o && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (inj_st && cyc == 3) begin
                start_i = 1; num_bins_i = '0;
            end else if (inj_st && cyc == 4) begin
                start_i = 0; num_bins_i = WB'(nb);
            end
        end
        chk({nm, "_done_seen"}, int'(done_o), 1);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, int'(done_o), 0);
        chk({nm, "_idle_after"}, int'(busy_o), 0);
        chk({nm, "_all_events_seen"}, rd, wr);
    endtask

    initial begin
        int  cyc;
        bit  found;
        rst = 0; start_i = 0; num_bins_i = '0;
        lat_load = 0; lat_core = 0; lat_store = 0; lat_bkt = 0; inj_load = 0;
        set_all_sat();
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", any_out(), 0);
        rst = 1;
        @(negedge clk);

        // Zero bins: straight to SAT, done at t+2, no loads.
        run("zero_bins", 0, 0, 1, cyc);
        chk("zero_bins_latency", cyc, 2);
        chk("zero_bins_sat", int'(sat_o), 1);
        chk("zero_bins_cnt", int'(load_cnt_o), 0);
        chk("zero_bins_loads", n_ld - b_ld, 0);

        // Three bins, all SAT, one-cycle responders.
        lat_load = 1; lat_core = 1; lat_store = 1; lat_bkt = 1;
        set_all_sat();
        run("three_sat", 3, 0, 10, cyc);
        chk("three_sat_sat", int'(sat_o), 1);
        chk("three_sat_unsat", int'(unsat_o), 0);
        chk("three_sat_cnt", int'(load_cnt_o), 3);
        chk("three_sat_cur", int'(cur_bin_o), 2);
        chk("three_sat_loads", n_ld - b_ld, 3);
        chk("three_sat_cores", n_co - b_co, 3);
        chk("three_sat_stores", n_st - b_st, 3);

        // Four bins, bin 2 backtracks to 0, then all SAT; zero-wait responders.
        lat_load = 0; lat_core = 0; lat_store = 0; lat_bkt = 0;
        set_all_sat();
        t_sat[2] = 0; t_unsat[2] = 1; t_bkt[2] = 0;
        run("bkt_to_0", 4, 0, 23, cyc);
        chk("bkt_to_0_sat", int'(sat_o), 1);
        chk("bkt_to_0_cnt", int'(load_cnt_o), 7);
        chk("bkt_to_0_bkts", n_bk - b_bk, 1);
        chk("bkt_to_0_cur", int'(cur_bin_o), 3);

        // Bin 1 root conflict: UNSAT, no error, no backtrack.
        lat_load = 1; lat_core = 0; lat_store = 2; lat_bkt = 1;
        set_all_sat();
        t_sat[1] = 0; t_unsat[1] = 1; t_root[1] = 1;
        run("root_conf", 3, 0, 7, cyc);
        chk("root_conf_unsat", int'(unsat_o), 1);
        chk("root_conf_sat", int'(sat_o), 0);
        chk("root_conf_err", int'(err_o), 0);
        chk("root_conf_bkts", n_bk - b_bk, 0);
        chk("root_conf_cur", int'(cur_bin_o), 1);

        // Bin 1 asks to backtrack to itself: illegal target.
        set_all_sat();
        t_sat[1] = 0; t_unsat[1] = 1; t_bkt[1] = 1;
        run("bad_target", 3, 0, 7, cyc);
        chk("bad_target_unsat", int'(unsat_o), 1);
        chk("bad_target_err", int'(err_o), 1);
        chk("bad_target_bkts", n_bk - b_bk, 0);

        // Inconsistent core answer, with stray start_i and done_load_i mid-solve.
        lat_load = 0; lat_core = 2; lat_store = 0; lat_bkt = 0; inj_load = 1;
        set_all_sat();
        t_unsat[0] = 1;
        run("both_flags", 2, 1, 4, cyc);
        inj_load = 0;
        chk("both_flags_err", int'(err_o), 1);
        chk("both_flags_unsat", int'(unsat_o), 1);
        chk("both_flags_sat", int'(sat_o), 0);
        chk("both_flags_loads", n_ld - b_ld, 1);

        // Twenty bins: load counter saturates at its all-ones value.
        lat_core = 0;
        set_all_sat();
        run("saturate", 20, 0, 61, cyc);
        chk("saturate_cnt", int'(load_cnt_o), MAXC);
        chk("saturate_cur", int'(cur_bin_o), 19);
        chk("saturate_sat", int'(sat_o), 1);

        // Reset while the core has a response pending.
        lat_core = 6;
        set_all_sat();
        sync_pos = wr;
        run_id++;
        build(3);
        @(negedge clk);
        num_bins_i = WB'(3);
        start_i = 1;
        @(negedge clk);
        start_i = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (start_core_o) found = 1;
        end
        chk("rst_reached_core", int'(found), 1);
        rst = 0;
        @(negedge clk);
        chk("rst_mid_core_outputs", any_out(), 0);
        rst = 1;
        @(negedge clk);
        chk("rst_stays_idle", any_out(), 0);
        lat_core = 0;
        run("after_rst", 2, 0, 7, cyc);
        chk("after_rst_sat", int'(sat_o), 1);
        chk("after_rst_cnt", int'(load_cnt_o), 2);
        chk("after_rst_cur", int'(cur_bin_o), 1);

        repeat (2) @(negedge clk);
        n_cmp += c_cmp;
        n_bad += c_bad;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
